// File: rtl/video_timing_pkg.sv
// Shared timing defaults (640x480 @ 60 Hz) and the per-axis phase encoding.
package video_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Counter width; covers totals up to 2048.
   localparam int CNT_W = 11;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_t;

   // Phase order along one axis: ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
   function automatic phase_t phase_after(input phase_t p);
      case (p)
         PH_ACTIVE: return PH_FP;
         PH_FP:     return PH_SYNC;
         PH_SYNC:   return PH_BP;
         default:   return PH_ACTIVE;
      endcase
   endfunction

endpackage

// File: rtl/timing_axis.sv
// One timing axis: position counter, phase FSM and sync decode.
// All registered outputs describe the count they sit next to; phase_nxt is
// exposed so the parent can register a combined display-enable alongside.
//
// state     | meaning
// ----------+---------------------------------------------
// PH_ACTIVE | visible region, cnt in [0, ACTIVE-1]
// PH_FP     | front porch
// PH_SYNC   | sync pulse, sync output at SYNC_POL
// PH_BP     | back porch, also the reset state (cnt = TOTAL-1)
//
// Every phase is assumed to be at least one count long.
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int   ACTIVE   = DEF_H_ACTIVE,
   parameter int   FP       = DEF_H_FP,
   parameter int   SYNC     = DEF_H_SYNC,
   parameter int   BP       = DEF_H_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   output logic [CNT_W-1:0] cnt,
   output logic             sync,
   output logic             wrap,
   output phase_t           phase_nxt
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
   localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
   localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);

   phase_t           phase;
   logic             phase_last;
   logic [CNT_W-1:0] cnt_nxt;

   // Is the counter sitting on the final count of the current phase?
   always_comb begin
      phase_last = 1'b0;
      case (phase)
         PH_ACTIVE: phase_last = (cnt == END_ACT);
         PH_FP:     phase_last = (cnt == END_FP);
         PH_SYNC:   phase_last = (cnt == END_SYNC);
         default:   phase_last = (cnt == LAST);
      endcase
   end

   // Next count/phase; both hold when the axis is not stepped.
   always_comb begin
      cnt_nxt   = cnt;
      phase_nxt = phase;
      wrap      = step && (cnt == LAST);
      if (step) begin
         cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
         if (phase_last) begin
            phase_nxt = phase_after(phase);
         end
      end
   end

   // Counter, phase and sync level registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= LAST;
         phase <= PH_BP;
         sync  <= ~SYNC_POL;
      end else if (step) begin
         cnt   <= cnt_nxt;
         phase <= phase_nxt;
         sync  <= (phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: horizontal axis stepped by i_en, vertical axis
// stepped by the horizontal wrap. Every output is registered on the same
// edge as the counters so all of them describe the same pixel.
module video_timing
   import video_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   output logic [10:0] o_hcnt,
   output logic [10:0] o_vcnt,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic        o_line_start,
   output logic        o_frame_start,
   output logic [15:0] o_frame_cnt
);

   logic   h_wrap;
   logic   v_wrap;
   phase_t h_phase_nxt;
   phase_t v_phase_nxt;

   timing_axis #(
      .ACTIVE   (H_ACTIVE),
      .FP       (H_FP),
      .SYNC     (H_SYNC),
      .BP       (H_BP),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .step      (i_en),
      .cnt       (o_hcnt),
      .sync      (o_hsync),
      .wrap      (h_wrap),
      .phase_nxt (h_phase_nxt)
   );

   timing_axis #(
      .ACTIVE   (V_ACTIVE),
      .FP       (V_FP),
      .SYNC     (V_SYNC),
      .BP       (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .step      (h_wrap),
      .cnt       (o_vcnt),
      .sync      (o_vsync),
      .wrap      (v_wrap),
      .phase_nxt (v_phase_nxt)
   );

   // Display enable, start strobes and frame counter, aligned with the counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_de          <= 1'b0;
         o_line_start  <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_cnt   <= '0;
      end else begin
         o_line_start  <= h_wrap;
         o_frame_start <= h_wrap && v_wrap;
         if (i_en) begin
            o_de <= (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
         end
         if (h_wrap && v_wrap) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default 800x525 instance for line-level checks and
// a small 20x13 instance (active-high syncs) for frame-level checks.
module tb_video_timing;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        en  [2];
   logic [10:0] hc  [2];
   logic [10:0] vc  [2];
   logic        hs  [2];
   logic        vs  [2];
   logic        de  [2];
   logic        ls  [2];
   logic        fs  [2];
   logic [15:0] fc  [2];

   video_timing u_vga (
      .clk           (clk),
      .rst           (rst[0]),
      .i_en          (en[0]),
      .o_hcnt        (hc[0]),
      .o_vcnt        (vc[0]),
      .o_hsync       (hs[0]),
      .o_vsync       (vs[0]),
      .o_de          (de[0]),
      .o_line_start  (ls[0]),
      .o_frame_start (fs[0]),
      .o_frame_cnt   (fc[0])
   );

   video_timing #(
      .H_ACTIVE (10), .H_FP (2), .H_SYNC (3), .H_BP (5),
      .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3),
      .SYNC_POL (1'b1)
   ) u_small (
      .clk           (clk),
      .rst           (rst[1]),
      .i_en          (en[1]),
      .o_hcnt        (hc[1]),
      .o_vcnt        (vc[1]),
      .o_hsync       (hs[1]),
      .o_vsync       (vs[1]),
      .o_de          (de[1]),
      .o_line_start  (ls[1]),
      .o_frame_start (fs[1]),
      .o_frame_cnt   (fc[1])
   );

   int p_ha [2] = '{640, 10};
   int p_hf [2] = '{16, 2};
   int p_hs [2] = '{96, 3};
   int p_hb [2] = '{48, 5};
   int p_va [2] = '{480, 6};
   int p_vf [2] = '{10, 2};
   int p_vs [2] = '{2, 2};
   int p_vb [2] = '{33, 3};
   bit p_pol[2] = '{1'b0, 1'b1};

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain position counters, decoded by range compare.
   int          mh  [2];
   int          mv  [2];
   logic [15:0] mfc [2];
   logic        mls [2];
   logic        mfs [2];
   bit          mon [2];

   function automatic int ht(input int i);
      return p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
   endfunction

   function automatic int vt(input int i);
      return p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
   endfunction

   task automatic model_reset(input int i);
      mh[i]  = ht(i) - 1;
      mv[i]  = vt(i) - 1;
      mfc[i] = 16'd0;
      mls[i] = 1'b0;
      mfs[i] = 1'b0;
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst[i]) begin
            if (en[i]) begin
               mh[i]++;
               if (mh[i] == ht(i)) begin
                  mh[i] = 0;
                  mv[i]++;
                  if (mv[i] == vt(i)) mv[i] = 0;
               end
               mls[i] = (mh[i] == 0);
               mfs[i] = (mh[i] == 0) && (mv[i] == 0);
               if (mfs[i]) mfc[i] = mfc[i] + 16'd1;
            end else begin
               mls[i] = 1'b0;
               mfs[i] = 1'b0;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mon[i]) begin
            logic e_de, e_hs, e_vs;
            e_de = (mh[i] < p_ha[i]) && (mv[i] < p_va[i]);
            e_hs = (mh[i] >= p_ha[i] + p_hf[i] && mh[i] < p_ha[i] + p_hf[i] + p_hs[i]) ? p_pol[i] : ~p_pol[i];
            e_vs = (mv[i] >= p_va[i] + p_vf[i] && mv[i] < p_va[i] + p_vf[i] + p_vs[i]) ? p_pol[i] : ~p_pol[i];
            chk($sformatf("u%0d_hcnt", i), 32'(hc[i]), 32'(mh[i]));
            chk($sformatf("u%0d_vcnt", i), 32'(vc[i]), 32'(mv[i]));
            chk($sformatf("u%0d_de", i), 32'(de[i]), 32'(e_de));
            chk($sformatf("u%0d_hsync", i), 32'(hs[i]), 32'(e_hs));
            chk($sformatf("u%0d_vsync", i), 32'(vs[i]), 32'(e_vs));
            chk($sformatf("u%0d_line_start", i), 32'(ls[i]), 32'(mls[i]));
            chk($sformatf("u%0d_frame_start", i), 32'(fs[i]), 32'(mfs[i]));
            chk($sformatf("u%0d_frame_cnt", i), 32'(fc[i]), 32'(mfc[i]));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst[0] = 1'b1; rst[1] = 1'b1;
      en[0]  = 1'b0; en[1]  = 1'b0;
      model_reset(0);
      model_reset(1);
      mon[0] = 1'b1; mon[1] = 1'b1;

      // Reset values
      #3;
      chk("rst_hcnt", 32'(hc[0]), 32'd799);
      chk("rst_vcnt", 32'(vc[0]), 32'd524);
      chk("rst_de", 32'(de[0]), 32'd0);
      chk("rst_hsync", 32'(hs[0]), 32'd1);
      chk("rst_vsync", 32'(vs[0]), 32'd1);
      chk("rst_strobes", 32'({ls[0], fs[0]}), 32'd0);
      chk("rst_frame_cnt", 32'(fc[0]), 32'd0);
      chk("rst_small_hcnt", 32'(hc[1]), 32'd19);
      chk("rst_small_hsync", 32'(hs[1]), 32'd0);

      // Reset release on the default instance with i_en=1
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      en[0]  = 1'b1;
      tick(1);
      chk("first_hcnt", 32'(hc[0]), 32'd0);
      chk("first_vcnt", 32'(vc[0]), 32'd0);
      chk("first_de", 32'(de[0]), 32'd1);
      chk("first_line_start", 32'(ls[0]), 32'd1);
      chk("first_frame_start", 32'(fs[0]), 32'd1);
      chk("first_frame_cnt", 32'(fc[0]), 32'd1);

      // Full line
      tick(639);
      chk("de_at_639", 32'(de[0]), 32'd1);
      tick(1);
      chk("hcnt_640", 32'(hc[0]), 32'd640);
      chk("de_at_640", 32'(de[0]), 32'd0);
      tick(15);
      chk("hsync_at_655", 32'(hs[0]), 32'd1);
      tick(1);
      chk("hsync_at_656", 32'(hs[0]), 32'd0);
      tick(95);
      chk("hsync_at_751", 32'(hs[0]), 32'd0);
      tick(1);
      chk("hsync_at_752", 32'(hs[0]), 32'd1);
      tick(47);
      chk("hcnt_799", 32'(hc[0]), 32'd799);
      chk("ls_at_799", 32'(ls[0]), 32'd0);
      tick(1);
      chk("wrap_hcnt", 32'(hc[0]), 32'd0);
      chk("wrap_vcnt", 32'(vc[0]), 32'd1);
      chk("wrap_line_start", 32'(ls[0]), 32'd1);
      chk("wrap_frame_start", 32'(fs[0]), 32'd0);

      // i_en at 50%: line period measured in enabled edges
      begin
         int  ecnt = 0;
         bit  started = 0;
         bit  done = 0;
         bit  pre;
         en[0] = 1'b0;
         for (int k = 0; k < 4000 && !done; k++) begin
            pre = en[0];
            @(negedge clk);
            if (pre) ecnt++;
            if (!pre) chk("strobe_while_idle", 32'({ls[0], fs[0]}), 32'd0);
            if (ls[0]) begin
               if (started) begin
                  chk("line_period", 32'(ecnt), 32'd800);
                  done = 1;
               end
               started = 1;
               ecnt = 0;
            end
            en[0] = ~en[0];
         end
         if (!done) chk("line_period_timeout", 32'(done), 32'd1);
         en[0] = 1'b0;
      end

      // Small instance: full frame
      en[1] = 1'b1;
      tick(1);
      chk("small_first_hv", 32'({hc[1], vc[1]}), 32'd0);
      chk("small_first_fs", 32'(fs[1]), 32'd1);
      chk("small_first_fc", 32'(fc[1]), 32'd1);
      tick(159);
      chk("small_vs_19_7", 32'(vs[1]), 32'd0);
      tick(1);
      chk("small_vs_0_8_h", 32'(hc[1]), 32'd0);
      chk("small_vs_0_8", 32'(vs[1]), 32'd1);
      tick(39);
      chk("small_vs_19_9", 32'(vs[1]), 32'd1);
      tick(1);
      chk("small_vs_0_10", 32'(vs[1]), 32'd0);
      tick(59);
      chk("small_end_h", 32'(hc[1]), 32'd19);
      chk("small_end_v", 32'(vc[1]), 32'd12);
      chk("small_end_fc", 32'(fc[1]), 32'd1);
      tick(1);
      chk("small_wrap_hv", 32'({hc[1], vc[1]}), 32'd0);
      chk("small_wrap_fs", 32'(fs[1]), 32'd1);
      chk("small_wrap_fc", 32'(fc[1]), 32'd2);

      // Mid-frame async reset
      tick(107);
      @(posedge clk);
      #2;
      chk("pre_rst_h", 32'(hc[1]), 32'd8);
      chk("pre_rst_v", 32'(vc[1]), 32'd5);
      rst[1] = 1'b1;
      model_reset(1);
      #1;
      chk("async_rst_h", 32'(hc[1]), 32'd19);
      chk("async_rst_v", 32'(vc[1]), 32'd12);
      chk("async_rst_de", 32'(de[1]), 32'd0);
      chk("async_rst_syncs", 32'({hs[1], vs[1]}), 32'd0);
      chk("async_rst_fc", 32'(fc[1]), 32'd0);
      @(negedge clk);
      rst[1] = 1'b0;
      tick(1);
      chk("resume_hv", 32'({hc[1], vc[1]}), 32'd0);
      chk("resume_de", 32'(de[1]), 32'd1);
      chk("resume_strobes", 32'({ls[1], fs[1]}), 32'd3);
      chk("resume_fc", 32'(fc[1]), 32'd1);

      // Frame counter wrap from 0xFFFF
      tick(258);
      @(posedge clk);
      #2;
      force u_small.o_frame_cnt = 16'hFFFF;
      mfc[1] = 16'hFFFF;
      #1;
      release u_small.o_frame_cnt;
      @(negedge clk);
      chk("preload_fc", 32'(fc[1]), 32'hFFFF);
      chk("preload_hv", 32'({hc[1], vc[1]}), 32'({11'd19, 11'd12}));
      tick(1);
      chk("wrap_fs", 32'(fs[1]), 32'd1);
      chk("wrap_fc", 32'(fc[1]), 32'h0000);

      en[1] = 1'b0;
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 SHALL have port clk, input, 1 bit, pixel clock; the single clock of the block.
REQ-011 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-012 SHALL have port i_en, input, 1 bit, pixel advance enable.
REQ-013 SHALL have port o_hcnt, output, 11 bits, current pixel column.
REQ-014 SHALL have port o_vcnt, output, 11 bits, current line.
REQ-015 SHALL have port o_hsync, output, 1 bit, horizontal sync.
REQ-016 SHALL have port o_vsync, output, 1 bit, vertical sync.
REQ-017 SHALL have port o_de, output, 1 bit, display enable (active video).
REQ-018 SHALL have port o_line_start, output, 1 bit, one-cycle strobe at hcnt 0.
REQ-019 SHALL have port o_frame_start, output, 1 bit, one-cycle strobe at (0,0).
REQ-020 SHALL have port o_frame_cnt, output, 16 bits, frames started since reset.

Function
REQ-021 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL likewise (default 525); both SHALL be <= 2048.
REQ-022 SHALL, on every clk with i_en=1, step o_hcnt by 1 and wrap it from H_TOTAL-1 to 0; on that wrap, o_vcnt SHALL step by 1 and wrap from V_TOTAL-1 to 0.
REQ-023 SHALL, with i_en=0, hold all counters and sync/de levels, and drive both strobes 0.
REQ-024 SHALL implement a per-axis phase FSM (ACTIVE -> FP -> SYNC -> BP -> ACTIVE); each transition occurs when the counter leaves the last count of the phase.
REQ-025 SHALL drive o_de=1 exactly when hcnt < H_ACTIVE and vcnt < V_ACTIVE.
REQ-026 SHALL drive o_hsync to SYNC_POL exactly for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else to ~SYNC_POL.
REQ-027 SHALL drive o_vsync to SYNC_POL exactly for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; vsync edges coincide with hcnt=0.
REQ-028 SHALL register all outputs, so that o_de, syncs and strobes are valid in the same cycle as the o_hcnt/o_vcnt values they describe (zero relative latency).
REQ-029 SHALL pulse o_line_start for one enabled cycle at hcnt=0, and o_frame_start at hcnt=0 and vcnt=0.
REQ-030 SHALL increment o_frame_cnt by 1 in the cycle o_frame_start asserts, wrapping from 0xFFFF to 0.

Reset
REQ-031 SHALL, while rst=1, force o_hcnt=H_TOTAL-1 and o_vcnt=V_TOTAL-1 (both phase FSMs in BP), o_de=0, syncs=~SYNC_POL, strobes=0, o_frame_cnt=0.
REQ-032 SHALL, on the first enabled clk after rst deasserts, present (0,0) with o_de=1, o_line_start=1, o_frame_start=1, o_frame_cnt=1.
REQ-033 SHALL act on rst asserted mid-frame immediately (asynchronously), without waiting for a clock edge.

Structure
REQ-034 SHALL place the default timing constants and the phase enum (ACTIVE, FP, SYNC, BP) in shared package video_timing_pkg.
REQ-035 SHALL instantiate one sub-module, timing_axis (counter + phase FSM + sync decode), twice: horizontal (stepped by i_en) and vertical (stepped by the horizontal wrap).

Verification
REQ-036 SHALL check reset release with i_en=1 -> first cycle hcnt=0, vcnt=0, de=1, both strobes=1, frame_cnt=1.
REQ-037 SHALL check a full line -> de falls at hcnt=640; hsync=0 for hcnt 656..751 and 1 elsewhere; hcnt wraps 799->0 with vcnt+1 and line_start=1.
REQ-038 SHALL check a full frame -> vsync=0 exactly for vcnt 490..491 with edges at hcnt=0; (799,524)->(0,0) with frame_start=1 and frame_cnt+1.
REQ-039 SHALL check i_en toggled at 50% -> counts advance only on enabled cycles; strobes never asserted while i_en=0; line period = 800 enabled cycles.
REQ-040 SHALL check rst pulsed at (300,200) -> outputs take REQ-031 values immediately and resume per REQ-032.
REQ-041 SHALL check frame_cnt preloaded to 0xFFFF via force -> next frame_start wraps it to 0x0000.
